// File: rtl/mcast_head_scheduler.sv
// mcast_head_scheduler: pops FIFO head flits and re-presents pending destinations until all accept.
// Optional MCAST_WAIT_CNT_EN adds a saturating wait_cnt of stalled SERVE cycles.
module mcast_head_scheduler #(
    parameter int NPORT    = 5,
    parameter int DATASIZE = 30,
    parameter int WCNT_W   = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                fifo_empty,
    input  logic [DATASIZE-1:0] fifo_data,
    input  logic [NPORT-1:0]    route_label,
    output logic                fifo_rd,
    output logic [NPORT-1:0]    req_label,
    output logic [DATASIZE-1:0] req_data,
    input  logic [NPORT-1:0]    accept,
    output logic                flit_done,
`ifdef MCAST_WAIT_CNT_EN
    output logic [WCNT_W-1:0]   wait_cnt,
`endif
    output logic                busy
);
    typedef enum logic {IDLE, SERVE} state_t;
    state_t state, next_state;
    logic [NPORT-1:0] pending, next_pending;
    logic [DATASIZE-1:0] head_data;
    logic serve_done, pop;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= next_state;

    always_comb begin
        next_pending = pending & ~accept;
        serve_done   = state == SERVE && next_pending == '0;
        pop          = rst_n && !fifo_empty && (state == IDLE || serve_done);
        next_state   = ((state == SERVE && !serve_done) || (pop && route_label != '0)) ? SERVE : IDLE;
    end

    always_comb begin
        fifo_rd   = pop;
        busy      = state == SERVE;
        req_label = busy ? pending : '0;
        req_data  = busy ? head_data : '0;
    end

    // A zero-label head is dropped on load; its done pulse merges with any completion in the same cycle.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            pending   <= '0;
            head_data <= '0;
            flit_done <= 1'b0;
        end else begin
            pending   <= pop ? route_label : (busy ? next_pending : pending);
            head_data <= pop ? fifo_data : head_data;
            flit_done <= serve_done || (pop && route_label == '0);
        end

`ifdef MCAST_WAIT_CNT_EN
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)                                        wait_cnt <= '0;
        else if (pop)                                      wait_cnt <= '0;
        else if (busy && !serve_done && wait_cnt != '1)    wait_cnt <= wait_cnt + 1'b1;
`endif
endmodule

// File: tb/tb_mcast_head_scheduler.sv
// tb_mcast_head_scheduler: table-driven cycle vectors plus hand-written stall/reset sequence.
module tb_mcast_head_scheduler;
    logic        clk = 0, rst_n = 0, fifo_empty = 1, fifo_rd, flit_done, busy;
    logic [29:0] fifo_data = '0, req_data;
    logic [4:0]  route_label = '0, accept = '0, req_label;
`ifdef MCAST_WAIT_CNT_EN
    logic [7:0]  wait_cnt;
`endif
    int total = 0, passed = 0;

    mcast_head_scheduler dut (
        .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .route_label(route_label), .fifo_rd(fifo_rd), .req_label(req_label),
        .req_data(req_data), .accept(accept), .flit_done(flit_done),
`ifdef MCAST_WAIT_CNT_EN
        .wait_cnt(wait_cnt),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        emp;
        logic [29:0] d;
        logic [4:0]  lbl;
        logic [4:0]  acc;
        logic        rd;
        logic [4:0]  rl;
        logic [29:0] rdat;
        logic        bsy;
        logic        done;
    } vec_t;
    vec_t v[25];

    task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    endtask

    task automatic check_row(input int i);
        chk("fifo_rd", i, 32'(fifo_rd), 32'(v[i].rd));
        chk("req_label", i, 32'(req_label), 32'(v[i].rl));
        chk("req_data", i, 32'(req_data), 32'(v[i].rdat));
        chk("busy", i, 32'(busy), 32'(v[i].bsy));
        chk("flit_done", i, 32'(flit_done), 32'(v[i].done));
    endtask

    localparam logic [29:0] A1 = 30'h0A1A1A1, A2 = 30'h12345678, B1 = 30'h0B1, B2 = 30'h0B2,
                            B3 = 30'h0B3, C0 = 30'h3CCCCCC, D0 = 30'h0DDDD, E0 = 30'h0EEEE,
                            F0 = 30'h0F0F0, G0 = 30'h2222222, H0 = 30'h1357ACE;

    initial begin
        //        emp  data  label     accept    rd   req_label req_data busy done
        v[0]  = '{1, '0, 5'b00000, 5'b00000, 0, 5'b00000, '0, 0, 0};
        v[1]  = '{0, A1, 5'b00100, 5'b00000, 1, 5'b00000, '0, 0, 0};
        v[2]  = '{1, '0, 5'b00000, 5'b00100, 0, 5'b00100, A1, 1, 0};
        v[3]  = '{1, '0, 5'b00000, 5'b00000, 0, 5'b00000, '0, 0, 1};
        v[4]  = '{0, A2, 5'b10011, 5'b00000, 1, 5'b00000, '0, 0, 0};
        v[5]  = '{1, '0, 5'b00000, 5'b00001, 0, 5'b10011, A2, 1, 0};
        v[6]  = '{1, '0, 5'b00000, 5'b10000, 0, 5'b10010, A2, 1, 0};
        v[7]  = '{1, '0, 5'b00000, 5'b00010, 0, 5'b00010, A2, 1, 0};
        v[8]  = '{1, '0, 5'b00000, 5'b00000, 0, 5'b00000, '0, 0, 1};
        v[9]  = '{0, B1, 5'b01000, 5'b00000, 1, 5'b00000, '0, 0, 0};
        v[10] = '{0, B2, 5'b01000, 5'b01000, 1, 5'b01000, B1, 1, 0};
        v[11] = '{0, B3, 5'b01000, 5'b01000, 1, 5'b01000, B2, 1, 1};
        v[12] = '{1, '0, 5'b00000, 5'b01000, 0, 5'b01000, B3, 1, 1};
        v[13] = '{1, '0, 5'b00000, 5'b00000, 0, 5'b00000, '0, 0, 1};
        v[14] = '{0, C0, 5'b00000, 5'b00000, 1, 5'b00000, '0, 0, 0};
        v[15] = '{1, '0, 5'b00000, 5'b00000, 0, 5'b00000, '0, 0, 1};
        v[16] = '{0, D0, 5'b00010, 5'b00000, 1, 5'b00000, '0, 0, 0};
        v[17] = '{0, E0, 5'b11111, 5'b11101, 0, 5'b00010, D0, 1, 0};
        v[18] = '{1, '0, 5'b00000, 5'b11101, 0, 5'b00010, D0, 1, 0};
        v[19] = '{1, '0, 5'b00000, 5'b00010, 0, 5'b00010, D0, 1, 0};
        v[20] = '{1, '0, 5'b00000, 5'b00000, 0, 5'b00000, '0, 0, 1};
        v[21] = '{0, F0, 5'b00001, 5'b00000, 1, 5'b00000, '0, 0, 0};
        v[22] = '{0, G0, 5'b00000, 5'b00001, 1, 5'b00001, F0, 1, 0};
        v[23] = '{1, '0, 5'b00000, 5'b00000, 0, 5'b00000, '0, 0, 1};
        v[24] = '{1, '0, 5'b00000, 5'b00000, 0, 5'b00000, '0, 0, 0};

        fifo_empty = 0;
        #1;
        chk("rd_in_reset", -1, 32'(fifo_rd), 32'd0);
        chk("label_in_reset", -1, 32'(req_label), 32'd0);
        fifo_empty = 1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        for (int i = 0; i < 25; i++) begin
            fifo_empty = v[i].emp; fifo_data = v[i].d; route_label = v[i].lbl; accept = v[i].acc;
            @(negedge clk);
            check_row(i);
            @(posedge clk);
            #1;
        end

        // stall then reset mid-SERVE
        fifo_empty = 0; fifo_data = H0; route_label = 5'b11000; accept = '0;
        @(negedge clk);
        chk("t5_pop", 100, 32'(fifo_rd), 32'd1);
        @(posedge clk); #1;
        fifo_empty = 1; route_label = '0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t5_label", 101 + k, 32'(req_label), 32'(5'b11000));
            chk("t5_data", 101 + k, 32'(req_data), 32'(H0));
            chk("t5_done", 101 + k, 32'(flit_done), 32'd0);
            @(posedge clk); #1;
        end
`ifdef MCAST_WAIT_CNT_EN
        chk("t5_wait_cnt", 106, 32'(wait_cnt), 32'd5);
`endif
        fifo_empty = 0; fifo_data = A1; route_label = 5'b00001; accept = 5'b11000;
        #2 rst_n = 0;
        #1;
        chk("rst_label", 107, 32'(req_label), 32'd0);
        chk("rst_data", 107, 32'(req_data), 32'd0);
        chk("rst_busy", 107, 32'(busy), 32'd0);
        chk("rst_rd", 107, 32'(fifo_rd), 32'd0);
        chk("rst_done", 107, 32'(flit_done), 32'd0);
`ifdef MCAST_WAIT_CNT_EN
        chk("rst_wait_cnt", 107, 32'(wait_cnt), 32'd0);
`endif
        fifo_empty = 1; accept = '0; route_label = '0;
        @(posedge clk); #1;
        rst_n = 1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("post_rst_done", 108 + k, 32'(flit_done), 32'd0);
            chk("post_rst_busy", 108 + k, 32'(busy), 32'd0);
            @(posedge clk); #1;
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
